// File: rtl/ioctl_sdram_writer.sv
// ============================================================================
// ioctl_sdram_writer
//
// Packs the byte-serial IO-controller download stream into 16-bit SDRAM write
// requests with byte strobes. Packed words are queued in a small FIFO and
// issued one at a time on the SDRAM controller's port1 req/ack toggle
// handshake.
//
// Ports:
//   clk              system / SDRAM clock
//   init_n           asynchronous active-low reset (shared with controller)
//   ioctl_download   high while a download is active
//   ioctl_wr         one-cycle byte strobe
//   ioctl_addr       byte address [AW:0]
//   ioctl_dout       byte data
//   ioctl_wait       host must not strobe while high
//   busy             pack register, FIFO or request still in flight
//   overflow         sticky drop flag, cleared on download rising edge
//   port1_req        toggle request
//   port1_ack        toggle acknowledge (done when ack == req)
//   port1_we         constant 1
//   port1_a          word address [AW:1]
//   port1_ds         byte strobes {hi, lo}
//   port1_d          write data
//
// Build option:
//   IOCTL_BYTE_SWAP_EN  when defined, even byte addresses map to the high
//                       lane and odd ones to the low lane (big-endian images).
// ============================================================================
module ioctl_sdram_writer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AW         = 23
) (
    input  logic          clk,
    input  logic          init_n,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [AW:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          ioctl_wait,
    output logic          busy,
    output logic          overflow,
    output logic          port1_req,
    input  logic          port1_ack,
    output logic          port1_we,
    output logic [AW:1]   port1_a,
    output logic [1:0]    port1_ds,
    output logic [15:0]   port1_d
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = AW + 18;   // {addr, ds, data}

    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0] WAIT_CNT = (PW+1)'(FIFO_DEPTH - 1);
    localparam logic [5:0]  TMO_LAST = 6'd63;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            dl_q;
    logic            pk_vld_q, pk_vld_d;
    logic [AW-1:0]   pk_a_q,   pk_a_d;
    logic [1:0]      pk_ds_q,  pk_ds_d;
    logic [15:0]     pk_d_q,   pk_d_d;
    logic [5:0]      tmo_q,    tmo_d;
    logic [PW:0]     cnt_q,    cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            ovf_q,    ovf_d;
    logic [0:0]      st_q,     st_d;
    logic            req_q,    req_d;
    logic [AW-1:0]   a_q,      a_d;
    logic [1:0]      ds_q,     ds_d;
    logic [15:0]     d_q,      d_d;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Incoming byte decode
    // ------------------------------------------------------------------
    logic            wr_ok, hi_lane, dl_fall, dl_rise;
    logic [1:0]      in_ds;
    logic [15:0]     in_d;
    logic [AW-1:0]   in_word;

    assign wr_ok   = ioctl_wr & ~ioctl_wait;
    assign dl_fall = dl_q & ~ioctl_download;
    assign dl_rise = ~dl_q & ioctl_download;
    assign in_word = ioctl_addr[AW:1];
`ifdef IOCTL_BYTE_SWAP_EN
    assign hi_lane = ~ioctl_addr[0];
`else
    assign hi_lane = ioctl_addr[0];
`endif
    assign in_ds = hi_lane ? 2'b10 : 2'b01;
    assign in_d  = hi_lane ? {ioctl_dout, 8'h00} : {8'h00, ioctl_dout};

    // ------------------------------------------------------------------
    // Pack register: decides what (if anything) is pushed this edge
    // ------------------------------------------------------------------
    logic            push_v;
    logic [EW-1:0]   push_w;

    always_comb begin
        push_v   = 1'b0;
        push_w   = {pk_a_q, pk_ds_q, pk_d_q};
        pk_vld_d = pk_vld_q;
        pk_a_d   = pk_a_q;
        pk_ds_d  = pk_ds_q;
        pk_d_d   = pk_d_q;
        tmo_d    = '0;
        if (wr_ok) begin
            if (pk_vld_q && (pk_a_q == in_word) && ((pk_ds_q & in_ds) == 2'b00)) begin
                // Complementary lane of the held word: complete it directly.
                push_v   = 1'b1;
                push_w   = {pk_a_q, 2'b11, pk_d_q | in_d};
                pk_vld_d = 1'b0;
            end else begin
                // Evict any held partial word and start a new one.
                push_v   = pk_vld_q;
                pk_vld_d = 1'b1;
                pk_a_d   = in_word;
                pk_ds_d  = in_ds;
                pk_d_d   = in_d;
            end
        end else if (pk_vld_q) begin
            // tmo_q counts idle clocks since load; the 64th flushes.
            if (dl_fall || (tmo_q == TMO_LAST)) begin
                push_v   = 1'b1;
                pk_vld_d = 1'b0;
            end else begin
                tmo_d = tmo_q + 6'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping, overflow and issue FSM
    // ------------------------------------------------------------------
    logic            pop, full, push_ok;
    logic [EW-1:0]   head;

    assign head    = mem_q[rd_ptr_q];
    assign pop     = (st_q == S_IDLE) && (cnt_q != '0);
    assign full    = (cnt_q == FULL_CNT);
    assign push_ok = push_v && !full;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        ovf_d = dl_rise ? 1'b0 : ovf_q;
        if ((push_v && full) || (ioctl_wr && ioctl_wait))
            ovf_d = 1'b1;

        st_d  = st_q;
        req_d = req_q;
        a_d   = a_q;
        ds_d  = ds_q;
        d_d   = d_q;
        case (st_q)
            S_IDLE: begin
                if (pop) begin
                    a_d   = head[EW-1:18];
                    ds_d  = head[17:16];
                    d_d   = head[15:0];
                    req_d = ~req_q;
                    st_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (port1_ack == req_q)
                    st_d = S_IDLE;
            end
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= push_w;
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            dl_q     <= 1'b0;
            pk_vld_q <= 1'b0;
            pk_a_q   <= '0;
            pk_ds_q  <= '0;
            pk_d_q   <= '0;
            tmo_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            st_q     <= S_IDLE;
            req_q    <= 1'b0;
            a_q      <= '0;
            ds_q     <= '0;
            d_q      <= '0;
        end else begin
            dl_q     <= ioctl_download;
            pk_vld_q <= pk_vld_d;
            pk_a_q   <= pk_a_d;
            pk_ds_q  <= pk_ds_d;
            pk_d_q   <= pk_d_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            st_q     <= st_d;
            req_q    <= req_d;
            a_q      <= a_d;
            ds_q     <= ds_d;
            d_q      <= d_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ioctl_wait = (cnt_q >= WAIT_CNT);
    assign busy       = pk_vld_q | (cnt_q != '0) | (st_q == S_WAIT);
    assign overflow   = ovf_q;
    assign port1_req  = req_q;
    assign port1_we   = 1'b1;
    assign port1_a    = a_q;
    assign port1_ds   = ds_q;
    assign port1_d    = d_q;

endmodule

// File: tb/tb_ioctl_sdram_writer.sv
// ============================================================================
// tb_ioctl_sdram_writer
//
// Bench for ioctl_sdram_writer: directed scenarios followed by randomized
// download bursts. Expected SDRAM requests come from a byte-level packing
// model that works on whole write events rather than clock cycles.
// Honours IOCTL_BYTE_SWAP_EN for lane mapping.
// ============================================================================
module tb_ioctl_sdram_writer;

    localparam int AW = 23;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          init_n;
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [AW:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wait;
    logic          busy;
    logic          overflow;
    logic          port1_req;
    logic          port1_ack;
    logic          port1_we;
    logic [AW:1]   port1_a;
    logic [1:0]    port1_ds;
    logic [15:0]   port1_d;

    always #5 clk = ~clk;

    ioctl_sdram_writer #(.FIFO_DEPTH(FD), .AW(AW)) dut (
        .clk            (clk),
        .init_n         (init_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .busy           (busy),
        .overflow       (overflow),
        .port1_req      (port1_req),
        .port1_ack      (port1_ack),
        .port1_we       (port1_we),
        .port1_a        (port1_a),
        .port1_ds       (port1_ds),
        .port1_d        (port1_d)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [1:0]    ds;
        logic [15:0]   d;
    } req_t;

    req_t        exp_q[$];
    req_t        last;
    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    int unsigned n_issued = 0;
    int unsigned stall_cycles = 0;
    logic        resp_en = 1'b1;
    logic        seen_req = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference packing model ----------------
    logic          m_vld = 1'b0;
    logic [AW-1:0] m_a;
    logic [1:0]    m_ds;
    logic [15:0]   m_d;

    task automatic model_wr(input logic [AW:0] addr, input logic [7:0] data);
        logic          hi;
        logic [AW-1:0] w;
        logic [1:0]    nds;
        logic [15:0]   nd;
        w = addr[AW:1];
`ifdef IOCTL_BYTE_SWAP_EN
        hi = (addr % 2) == 0;
`else
        hi = (addr % 2) == 1;
`endif
        nds = hi ? 2'b10 : 2'b01;
        nd  = hi ? {data, 8'h00} : {8'h00, data};
        if (m_vld && m_a == w && m_ds != nds) begin
            exp_q.push_back('{w, 2'b11, m_d | nd});
            m_vld = 1'b0;
        end else begin
            if (m_vld) exp_q.push_back('{m_a, m_ds, m_d});
            m_vld = 1'b1;
            m_a   = w;
            m_ds  = nds;
            m_d   = nd;
        end
    endtask

    task automatic model_flush();
        if (m_vld) exp_q.push_back('{m_a, m_ds, m_d});
        m_vld = 1'b0;
    endtask

    // ---------------- SDRAM port model: scoreboard + responder ----------------
    initial begin
        port1_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!init_n) begin
                seen_req  = 1'b0;
                port1_ack = 1'b0;
            end else if (port1_req !== seen_req) begin
                req_t e;
                int unsigned dly;
                seen_req = port1_req;
                n_issued++;
                last.a  = port1_a;
                last.ds = port1_ds;
                last.d  = port1_d;
                check_eq("req_expected", 32'(exp_q.size() > 0), 32'd1);
                check_eq("req_we", 32'(port1_we), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("req_a",  32'(port1_a),  32'(e.a));
                    check_eq("req_ds", 32'(port1_ds), 32'(e.ds));
                    check_eq("req_d",  32'(port1_d),  32'(e.d));
                end
                if (resp_en) begin
                    dly = (stall_cycles > 0) ? stall_cycles : $urandom_range(0, 5);
                    stall_cycles = 0;
                    for (int unsigned i = 0; i < dly && init_n; i++) @(negedge clk);
                    if (init_n) begin
                        check_eq("hold_a",  32'(port1_a),  32'(last.a));
                        check_eq("hold_ds", 32'(port1_ds), 32'(last.ds));
                        check_eq("hold_d",  32'(port1_d),  32'(last.d));
                        port1_ack = port1_req;
                    end
                end
            end
        end
    end

    // ---------------- host driver ----------------
    task automatic send_byte(input logic [AW:0] addr, input logic [7:0] data);
        int unsigned n = 0;
        while (ioctl_wait && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check_eq("wait_bound", 32'(n), 32'd0);
        model_wr(addr, data);
        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
    endtask

    task automatic dl_up();
        ioctl_download = 1'b1;
        @(negedge clk);
    endtask

    task automatic dl_down();
        ioctl_download = 1'b0;
        model_flush();
        @(negedge clk);
    endtask

    task automatic wait_quiet(input string tag);
        int unsigned n = 0;
        while ((busy !== 1'b0 || port1_req !== port1_ack) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(n < 3000), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int unsigned saved;
        logic [AW:0] base, addr;
        init_n = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        repeat (3) @(negedge clk);

        check_eq("rst_req",  32'(port1_req),  32'd0);
        check_eq("rst_a",    32'(port1_a),    32'd0);
        check_eq("rst_ds",   32'(port1_ds),   32'd0);
        check_eq("rst_d",    32'(port1_d),    32'd0);
        check_eq("rst_wait", 32'(ioctl_wait), 32'd0);
        check_eq("rst_busy", 32'(busy),       32'd0);
        check_eq("rst_ovf",  32'(overflow),   32'd0);
        init_n = 1'b1;
        @(negedge clk);

        // Full word from two bytes
        dl_up();
        send_byte(24'h000000, 8'h11);
        send_byte(24'h000001, 8'h22);
        wait_quiet("t1_quiet");
        check_eq("t1_req", 32'(port1_req), 32'd1);
        check_eq("t1_a",   32'(last.a),    32'h0);
        check_eq("t1_ds",  32'(last.ds),   32'h3);
`ifdef IOCTL_BYTE_SWAP_EN
        check_eq("t1_d",   32'(last.d),    32'h1122);
`else
        check_eq("t1_d",   32'(last.d),    32'h2211);
`endif

        // Single byte flushed by download falling edge
        send_byte(24'h000005, 8'hAB);
        repeat (3) @(negedge clk);
        check_eq("t2_busy_hold", 32'(busy), 32'd1);
        check_eq("t2_no_early", 32'(n_issued), 32'd1);
        dl_down();
        wait_quiet("t2_quiet");
        check_eq("t2_a", 32'(last.a), 32'h2);
`ifdef IOCTL_BYTE_SWAP_EN
        check_eq("t2_ds", 32'(last.ds), 32'h1);
        check_eq("t2_d",  32'(last.d),  32'h00AB);
`else
        check_eq("t2_ds", 32'(last.ds), 32'h2);
        check_eq("t2_d",  32'(last.d),  32'hAB00);
`endif

        // Two unrelated words
        dl_up();
        send_byte(24'h000010, 8'h01);
        send_byte(24'h000020, 8'h02);
        dl_down();
        wait_quiet("t3_quiet");
        check_eq("t3_count", 32'(n_issued), 32'd4);
        check_eq("t3_a", 32'(last.a), 32'h10);
`ifdef IOCTL_BYTE_SWAP_EN
        check_eq("t3_d", 32'(last.d), 32'h0200);
`else
        check_eq("t3_d", 32'(last.d), 32'h0002);
`endif

        // Stalled ack: wait asserts once three words are queued
        dl_up();
        stall_cycles = 100;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check_eq("t4_wait_low", 32'(ioctl_wait), 32'd0);
            send_byte(24'h000040 + 24'(i), 8'h30 + 8'(i));
        end
        check_eq("t4_wait_high", 32'(ioctl_wait), 32'd1);
        check_eq("t4_ovf", 32'(overflow), 32'd0);
        wait_quiet("t4_quiet");
        check_eq("t4_count", 32'(n_issued), 32'd8);
        check_eq("t4_ovf_end", 32'(overflow), 32'd0);

        // Overflow: fill FIFO, host ignores wait
        stall_cycles = 150;
        for (int i = 0; i < 7; i++) send_byte(24'h000080 + 24'(i), 8'h50 + 8'(i));
        send_byte(24'h000088, 8'h58);
        check_eq("t5_wait", 32'(ioctl_wait), 32'd1);
        dl_down();
        check_eq("t5_ovf_pre", 32'(overflow), 32'd0);
        ioctl_addr = 24'h00008A;
        ioctl_dout = 8'hEE;
        ioctl_wr = 1'b1;
        @(negedge clk);
        ioctl_wr = 1'b0;
        @(negedge clk);
        check_eq("t5_ovf_set", 32'(overflow), 32'd1);
        wait_quiet("t5_quiet");
        check_eq("t5_ovf_sticky", 32'(overflow), 32'd1);
        dl_up();
        check_eq("t5_ovf_clr", 32'(overflow), 32'd0);

        // Timeout flush of a held partial word
        saved = n_issued;
        send_byte(24'h000101, 8'h5A);
        repeat (40) @(negedge clk);
        check_eq("t6_no_early", 32'(n_issued), 32'(saved));
        model_flush();
        wait_quiet("t6_quiet");
        check_eq("t6_flushed", 32'(n_issued), 32'(saved + 1));
        dl_down();

        // Randomized bursts
        for (int b = 0; b < 20; b++) begin
            int unsigned n;
            logic seq;
            dl_up();
            n    = $urandom_range(1, 12);
            seq  = 1'($urandom_range(0, 1));
            base = (AW+1)'($urandom);
            for (int unsigned i = 0; i < n; i++) begin
                addr = seq ? base + (AW+1)'(i) : base + (AW+1)'($urandom_range(0, 5));
                send_byte(addr, 8'($urandom));
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            dl_down();
            wait_quiet("rnd_quiet");
            check_eq("rnd_drained", 32'(exp_q.size()), 32'd0);
            check_eq("rnd_ovf", 32'(overflow), 32'd0);
        end

        // Reset while a request is outstanding
        resp_en = 1'b0;
        dl_up();
        send_byte(24'h000200, 8'h77);
        send_byte(24'h000201, 8'h88);
        send_byte(24'h000300, 8'h99);
        send_byte(24'h000302, 8'h9A);
        check_eq("t7_outstanding", 32'(port1_req != port1_ack), 32'd1);
        check_eq("t7_busy_pre", 32'(busy), 32'd1);
        init_n = 1'b0;
        #1;
        check_eq("t7_req_rst",  32'(port1_req), 32'd0);
        check_eq("t7_busy_rst", 32'(busy),      32'd0);
        exp_q.delete();
        m_vld = 1'b0;
        @(negedge clk);
        init_n = 1'b1;
        @(negedge clk);
        check_eq("t7_busy_after", 32'(busy),       32'd0);
        check_eq("t7_wait_after", 32'(ioctl_wait), 32'd0);
        check_eq("t7_req_after",  32'(port1_req),  32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
